// File: rtl/seq_detector.sv
// Serial pattern detector: compares the last LEN accepted symbols against a
// loadable pattern, pulses match on completion and keeps a saturating count.
module seq_detector #(
    parameter int SYM_W = 2,
    parameter int LEN   = 3,
    parameter int CNT_W = 8,
    localparam int FILL_W = $clog2(LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [SYM_W-1:0]     in_sym,
    input  logic                 cfg_load,
    input  logic [LEN*SYM_W-1:0] pattern,
    input  logic                 overlap,
    input  logic                 clr_count,
    output logic                 match,
    output logic [CNT_W-1:0]     match_count,
    output logic [FILL_W-1:0]    progress
);

    localparam logic [FILL_W-1:0] FULL = FILL_W'(LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [LEN*SYM_W-1:0] pat_q;
    logic [LEN*SYM_W-1:0] history;
    logic [FILL_W-1:0]    fill;

    logic [LEN*SYM_W-1:0] new_hist;
    logic [FILL_W-1:0]    new_fill;
    logic                 hit;

    // Symbol 0 sits in the low bits and is the oldest, so history lines up
    // with the pattern layout and a plain vector compare is symbol-wise.
    always_comb begin
        new_hist = {in_sym, history[LEN*SYM_W-1:SYM_W]};
        new_fill = (fill == FULL) ? fill : fill + FILL_W'(1);
        hit      = in_valid && !cfg_load && (new_fill == FULL) && (new_hist == pat_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q       <= '0;
            history     <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            if (cfg_load) begin
                pat_q <= pattern;
                fill  <= '0;
                match <= 1'b0;
            end else if (in_valid) begin
                history <= new_hist;
                match   <= hit;
                fill    <= (hit && !overlap) ? '0 : new_fill;
            end else begin
                match <= 1'b0;
            end

            // Counter is independent of cfg_load; a clear coincident with a
            // hit leaves that hit counted.
            if (clr_count)
                match_count <= hit ? CNT_W'(1) : '0;
            else if (hit && match_count != CNT_MAX)
                match_count <= match_count + CNT_W'(1);
        end
    end

    assign progress = fill;

endmodule
